// File: rtl/imem_program_loader_pkg.sv
// ISA opcode map, word field positions and shared types for the imem loader.
// The control decoder imports the same package, so encode and decode stay in lockstep.
package imem_program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII,
    FMT_BAD
  } fmt_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int SH_MSB  = 11;
  localparam int SH_LSB  = 7;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;
  localparam int IMM_MSB = 16;
  localparam int TGT_MSB = 26;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [16:0] imm;
    logic [26:0] target;
  } fields_t;

  function automatic fmt_t fmt_of(input logic [4:0] opcode);
    fmt_t f;
    case (opcode)
      OP_RTYPE:                            f = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: f = FMT_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:       f = FMT_JI;
      OP_JR:                               f = FMT_JII;
      default:                             f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imem_program_loader_encode.sv
// Combinational field packer: builds one 32-bit ISA word from decoded fields.
// Bits not used by a format are left at zero; unknown opcodes raise illegal.
module instr_encode
  import imem_program_loader_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        illegal
);

  fmt_t fmt;

  assign fmt = fmt_of(fields.opcode);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OPC_MSB:OPC_LSB] = fields.opcode;
        word[RD_MSB:RD_LSB]   = fields.rd;
        word[RS_MSB:RS_LSB]   = fields.rs;
        word[RT_MSB:RT_LSB]   = fields.rt;
        word[SH_MSB:SH_LSB]   = fields.shamt;
        word[ALU_MSB:ALU_LSB] = fields.aluop;
      end
      FMT_I: begin
        word[OPC_MSB:OPC_LSB] = fields.opcode;
        word[RD_MSB:RD_LSB]   = fields.rd;
        word[RS_MSB:RS_LSB]   = fields.rs;
        word[IMM_MSB:0]       = fields.imm;
      end
      FMT_JI: begin
        word[OPC_MSB:OPC_LSB] = fields.opcode;
        word[TGT_MSB:0]       = fields.target;
      end
      FMT_JII: begin
        word[OPC_MSB:OPC_LSB] = fields.opcode;
        word[RD_MSB:RD_LSB]   = fields.rd;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Streams encoded instructions into consecutive imem addresses while holding the CPU.
// One word per two cycles: accept in LOAD, strobe imem_we in WRITE.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              fld_valid,
  output logic              fld_ready,
  input  logic [4:0]        fld_opcode,
  input  logic [4:0]        fld_rd,
  input  logic [4:0]        fld_rs,
  input  logic [4:0]        fld_rt,
  input  logic [4:0]        fld_shamt,
  input  logic [4:0]        fld_aluop,
  input  logic [16:0]       fld_imm,
  input  logic [26:0]       fld_target,
  input  logic              fld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t      state_reg;
  logic        last_reg;
  fields_t     fields;
  logic [31:0] enc_word;
  logic        enc_illegal;

  assign fields = '{
    opcode: fld_opcode,
    rd:     fld_rd,
    rs:     fld_rs,
    rt:     fld_rt,
    shamt:  fld_shamt,
    aluop:  fld_aluop,
    imm:    fld_imm,
    target: fld_target
  };

  instr_encode u_encode (
    .fields  (fields),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // imem_addr doubles as the address counter, so the write address is always a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      last_reg   <= 1'b0;
      fld_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            err        <= 1'b0;
            word_count <= '0;
            imem_addr  <= BASE;
            fld_ready  <= 1'b1;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fld_valid) begin
            if (!enc_illegal) begin
              imem_wdata <= enc_word;
              imem_we    <= 1'b1;
              last_reg   <= fld_last;
              fld_ready  <= 1'b0;
              state_reg  <= ST_WRITE;
            end else begin
              err <= 1'b1;
              if (fld_last) begin
                fld_ready <= 1'b0;
                done      <= 1'b1;
                state_reg <= ST_DONE;
              end
            end
          end
        end
        ST_WRITE: begin
          word_count <= word_count + (ADDR_W+1)'(1);
          // Hold the address at the top of memory rather than wrapping to zero.
          if (imem_addr != LAST_ADDR) begin
            imem_addr <= imem_addr + ADDR_W'(1);
          end
          if (last_reg) begin
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else if (imem_addr == LAST_ADDR) begin
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            fld_ready <= 1'b1;
            state_reg <= ST_LOAD;
          end
        end
        ST_DONE: begin
          cpu_hold  <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized session bench: two loaders (4096-deep and 4-deep) share one field stream
// and are scored against a transaction-level list of expected imem writes.
module tb_imem_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fld_valid = 1'b0;
  logic        fld_last = 1'b0;
  logic [4:0]  fld_opcode = '0, fld_rd = '0, fld_rs = '0, fld_rt = '0;
  logic [4:0]  fld_shamt = '0, fld_aluop = '0;
  logic [16:0] fld_imm = '0;
  logic [26:0] fld_target = '0;

  logic        a_ready, a_we, a_hold, a_busy, a_done, a_err;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [12:0] a_wc;
  logic        b_ready, b_we, b_hold, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_wc;

  always #5 clock = ~clock;

  imem_program_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .fld_valid(fld_valid), .fld_ready(a_ready),
    .fld_opcode(fld_opcode), .fld_rd(fld_rd), .fld_rs(fld_rs), .fld_rt(fld_rt),
    .fld_shamt(fld_shamt), .fld_aluop(fld_aluop), .fld_imm(fld_imm), .fld_target(fld_target),
    .fld_last(fld_last), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .err(a_err), .word_count(a_wc)
  );

  imem_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .fld_valid(fld_valid), .fld_ready(b_ready),
    .fld_opcode(fld_opcode), .fld_rd(fld_rd), .fld_rs(fld_rs), .fld_rt(fld_rt),
    .fld_shamt(fld_shamt), .fld_aluop(fld_aluop), .fld_imm(fld_imm), .fld_target(fld_target),
    .fld_last(fld_last), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .err(b_err), .word_count(b_wc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op, rd, rs, rt, sh, alu;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic        last;
  } bundle_t;

  bundle_t sess[$];

  int          exp_addr[2][$];
  logic [31:0] exp_data[2][$];
  logic        exp_err[2];
  bit          exp_tail_write[2];
  int          got_addr[2][$];
  logic [31:0] got_data[2][$];
  int          viol[2], done_cnt[2], done_cyc[2], last_we_cyc[2];
  bit          prev_we[2];
  int          cycle = 0;

  function automatic bundle_t mk(int op, int rd, int rs, int rt, int sh, int alu,
                                 int imm, int tgt, bit last);
    bundle_t b;
    b.op = 5'(op); b.rd = 5'(rd); b.rs = 5'(rs); b.rt = 5'(rt);
    b.sh = 5'(sh); b.alu = 5'(alu); b.imm = 17'(imm); b.tgt = 27'(tgt); b.last = last;
    return b;
  endfunction

  function automatic bit ref_encode(input bundle_t b, output logic [31:0] w);
    int op;
    op = int'(b.op);
    w = 32'(op) << 27;
    if (op == 0)
      w = w | (32'(b.rd) << 22) | (32'(b.rs) << 17) | (32'(b.rt) << 12)
            | (32'(b.sh) << 7) | (32'(b.alu) << 2);
    else if (op == 5 || op == 7 || op == 8 || op == 2 || op == 6)
      w = w | (32'(b.rd) << 22) | (32'(b.rs) << 17) | 32'(b.imm);
    else if (op == 1 || op == 3 || op == 21 || op == 22)
      w = w | 32'(b.tgt);
    else if (op == 4)
      w = w | (32'(b.rd) << 22);
    else begin
      w = 0;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bundle_t rand_bundle(bit last);
    int legal_ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
    int op;
    logic [31:0] dummy;
    bundle_t b;
    op = legal_ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 7) == 0) begin
      do begin
        op = int'($urandom_range(0, 31));
        b = mk(op, 0, 0, 0, 0, 0, 0, 0, 0);
      end while (ref_encode(b, dummy));
    end
    b = mk(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 131071)),
           int'($urandom & 32'h07FF_FFFF), last);
    return b;
  endfunction

  // Expected writes for a memory of the given depth, straight from the session rules.
  task automatic build_expect(input int d, input int depth);
    int addr;
    logic [31:0] w;
    exp_addr[d].delete();
    exp_data[d].delete();
    exp_err[d] = 1'b0;
    exp_tail_write[d] = 1'b0;
    addr = 0;
    foreach (sess[i]) begin
      if (ref_encode(sess[i], w)) begin
        exp_addr[d].push_back(addr);
        exp_data[d].push_back(w);
        exp_tail_write[d] = 1'b1;
        if (sess[i].last) break;
        if (addr == depth - 1) begin
          exp_err[d] = 1'b1;
          break;
        end
        addr++;
      end else begin
        exp_err[d] = 1'b1;
        exp_tail_write[d] = 1'b0;
        if (sess[i].last) break;
      end
    end
  endtask

  task automatic mon(input int d, input logic we, input int addr, input logic [31:0] data,
                     input logic dn, input logic hold, input logic bsy, input logic rdy);
    if (reset) begin
      prev_we[d] = 1'b0;
      return;
    end
    if (we === 1'b1) begin
      got_addr[d].push_back(addr);
      got_data[d].push_back(data);
      last_we_cyc[d] = cycle;
      if (prev_we[d]) viol[d]++;
    end
    prev_we[d] = (we === 1'b1);
    if (dn === 1'b1) begin
      done_cnt[d]++;
      done_cyc[d] = cycle;
    end
    if (hold !== bsy) viol[d]++;
    if (rdy === 1'b1 && we === 1'b1) viol[d]++;
  endtask

  always @(negedge clock) begin
    mon(0, a_we, int'(a_addr), a_wdata, a_done, a_hold, a_busy, a_ready);
    mon(1, b_we, int'(b_addr), b_wdata, b_done, b_hold, b_busy, b_ready);
    cycle++;
  end

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      got_addr[d].delete();
      got_data[d].delete();
      viol[d] = 0;
      done_cnt[d] = 0;
      done_cyc[d] = -1;
      last_we_cyc[d] = -100;
    end
  endtask

  task automatic drive(input bundle_t b);
    fld_valid = 1'b1;
    fld_opcode = b.op; fld_rd = b.rd; fld_rs = b.rs; fld_rt = b.rt;
    fld_shamt = b.sh; fld_aluop = b.alu; fld_imm = b.imm; fld_target = b.tgt;
    fld_last = b.last;
  endtask

  task automatic run_session(input string name, input bit gaps, input bit noise);
    int idx, guard;
    build_expect(0, 4096);
    build_expect(1, 4);
    @(negedge clock);
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < sess.size() && guard < 500) begin
      if (a_ready && !(gaps && $urandom_range(0, 3) == 0)) begin
        drive(sess[idx]);
        idx++;
      end else if (noise && a_ready) begin
        start = 1'b1;
      end
      @(negedge clock);
      fld_valid = 1'b0;
      start = 1'b0;
      guard++;
    end
    while ((a_busy || b_busy) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    check({name, "_finished"}, guard < 500, 1'b1);
    for (int d = 0; d < 2; d++) begin
      string p;
      p = $sformatf("%s_d%0d", name, d);
      check({p, "_nwrites"}, got_addr[d].size(), exp_addr[d].size());
      for (int i = 0; i < exp_addr[d].size() && i < got_addr[d].size(); i++) begin
        check($sformatf("%s_addr%0d", p, i), got_addr[d][i], exp_addr[d][i]);
        check($sformatf("%s_data%0d", p, i), got_data[d][i], exp_data[d][i]);
      end
      check({p, "_err"}, (d == 0) ? a_err : b_err, exp_err[d]);
      check({p, "_wcount"}, (d == 0) ? 64'(a_wc) : 64'(b_wc), exp_addr[d].size());
      check({p, "_done_cnt"}, done_cnt[d], 1);
      check({p, "_protocol"}, viol[d], 0);
      if (exp_tail_write[d])
        check({p, "_done_timing"}, done_cyc[d], last_we_cyc[d] + 1);
    end
    $display("session %s: %0d/%0d words, err %0d/%0d", name, got_addr[0].size(),
             got_addr[1].size(), a_err, b_err);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, {a_ready, b_ready}, 0);
    check({name, "_we"}, {a_we, b_we}, 0);
    check({name, "_addr"}, {a_addr, b_addr}, 0);
    check({name, "_wdata"}, {a_wdata, b_wdata}, 0);
    check({name, "_hold"}, {a_hold, b_hold}, 0);
    check({name, "_busy"}, {a_busy, b_busy}, 0);
    check({name, "_done"}, {a_done, b_done}, 0);
    check({name, "_err"}, {a_err, b_err}, 0);
    check({name, "_wcount"}, {a_wc, b_wc}, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    sess.delete();
    sess.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0, 1));
    run_session("add", 0, 0);
    check("tp_add_word", got_data[0].size() > 0 ? got_data[0][0] : 32'hDEAD, 32'h00443000);

    sess.delete();
    sess.push_back(mk(5, 5, 0, 0, 0, 0, 'h1FFFF, 0, 0));
    sess.push_back(mk(7, 4, 6, 0, 0, 0, 8, 0, 0));
    sess.push_back(mk(1, 0, 0, 0, 0, 0, 0, 100, 1));
    run_session("stream", 0, 0);
    check("tp_stream_w2", got_data[0].size() > 2 ? got_data[0][2] : 32'hDEAD, 32'h08000064);

    sess.delete();
    sess.push_back(mk(4, 31, 0, 0, 0, 0, 0, 0, 0));
    sess.push_back(mk(31, 0, 0, 0, 0, 0, 0, 0, 1));
    run_session("illegal", 0, 0);
    check("tp_jr_word", got_data[0].size() > 0 ? got_data[0][0] : 32'hDEAD, 32'h27C00000);

    sess.delete();
    for (int i = 0; i < 5; i++) sess.push_back(mk(5, i, i + 1, 0, 0, 0, i * 3, 0, 0));
    sess.push_back(mk(3, 0, 0, 0, 0, 0, 0, 77, 1));
    run_session("overflow", 0, 0);

    // Reset in the middle of a WRITE cycle.
    sess.delete();
    sess.push_back(mk(8, 9, 10, 0, 0, 0, 1234, 0, 0));
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drive(sess[0]);
    @(negedge clock);
    fld_valid = 1'b0;
    check("pre_reset_we", {a_we, b_we}, 2'b11);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;

    sess.delete();
    sess.push_back(mk(0, 7, 8, 9, 10, 11, 0, 0, 0));
    sess.push_back(mk(6, 1, 2, 0, 0, 0, 5, 0, 1));
    run_session("after_reset", 0, 0);

    // fld_valid held while idle must not be accepted.
    @(negedge clock);
    clear_mon();
    drive(mk(5, 1, 1, 0, 0, 0, 1, 0, 1));
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (a_ready || b_ready || a_hold || b_hold || a_busy || b_busy) n++;
    end
    fld_valid = 1'b0;
    check("idle_valid_ignored", n, 0);
    check("idle_valid_nwrites", got_addr[0].size() + got_addr[1].size(), 0);

    sess.delete();
    for (int i = 0; i < 3; i++) sess.push_back(rand_bundle(i == 2));
    sess[0].op = 5'd0;
    run_session("start_noise", 1, 1);

    for (int s = 0; s < 15; s++) begin
      int len;
      len = int'($urandom_range(1, 7));
      sess.delete();
      for (int i = 0; i < len; i++) sess.push_back(rand_bundle(i == len - 1));
      run_session($sformatf("rand%0d", s), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
